// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants, state encoding and sizing helper for seg_scan_ctrl
package seg_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Wide enough to hold max(a, b) - 1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// rtl/seg_scan_ctrl_dec.sv - hex nibble to active-low 7-segment pattern, bit7 (dp) left dark
module seg_scan_ctrl_dec (
    input  logic [3:0] code,
    output logic [7:0] patt
);

    always_comb begin
        case (code)
            4'h0:    patt = 8'hC0;
            4'h1:    patt = 8'hF9;
            4'h2:    patt = 8'hA4;
            4'h3:    patt = 8'hB0;
            4'h4:    patt = 8'h99;
            4'h5:    patt = 8'h92;
            4'h6:    patt = 8'h82;
            4'h7:    patt = 8'hF8;
            4'h8:    patt = 8'h80;
            4'h9:    patt = 8'h90;
            4'hA:    patt = 8'h88;
            4'hB:    patt = 8'h83;
            4'hC:    patt = 8'hC6;
            4'hD:    patt = 8'hA1;
            4'hE:    patt = 8'h86;
            default: patt = 8'h8E;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - N-digit multiplexed 7-segment scanner with tear-free shadow and commit handshake
// Optional leading-zero suppression when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    upd_req,
    output logic                    upd_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_start
);

    localparam int CW = cnt_width(SCAN_DIV, BLANK_CYC);
    localparam int IW = (NUM_DIGITS <= 2) ? 1 : $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DRIVE_LOAD = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    scan_state_t               state;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   data_sh;
    logic [NUM_DIGITS-1:0]     dp_sh;
    logic [NUM_DIGITS-1:0]     en_sh;

    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [3:0]                nib;
    logic                      dp_cur;
    logic                      en_cur;
    logic                      lz_cur;
    logic [7:0]                patt;
    logic [7:0]                digit_seg;
    logic [NUM_DIGITS-1:0]     digit_an;

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Walk from the most significant digit down; the run of suppressible
    // zeros ends at the first lit dp or the first enabled non-zero digit.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (dp_sh[i]) run = 1'b0;
            if (run && (data_sh[4*i +: 4] == 4'h0)) lz_mask[i] = 1'b1;
            if (en_sh[i] && (data_sh[4*i +: 4] != 4'h0)) run = 1'b0;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        nib    = 4'h0;
        dp_cur = 1'b0;
        en_cur = 1'b0;
        lz_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib    = data_sh[4*i +: 4];
                dp_cur = dp_sh[i];
                en_cur = en_sh[i];
                lz_cur = lz_mask[i];
            end
        end
    end

    seg_scan_ctrl_dec u_dec (
        .code (nib),
        .patt (patt)
    );

    always_comb begin
        digit_seg = {patt[7] & ~dp_cur, patt[6:0]};
        if (!en_cur || lz_cur) digit_seg = SEG_BLANK;
    end

    always_comb begin
        digit_an = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) digit_an[i] = ~en_cur;
        end
    end

    // idx only moves on DRIVE exit, so on BLANK exit the selected digit is already the one being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            data_sh     <= '0;
            dp_sh       <= '0;
            en_sh       <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                BLANK: begin
                    if (cnt == '0) begin
                        state       <= DRIVE;
                        cnt         <= DRIVE_LOAD;
                        an          <= digit_an;
                        seg         <= digit_seg;
                        frame_start <= (idx == '0);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state <= BLANK;
                        cnt   <= BLANK_LOAD;
                        an    <= '1;
                        seg   <= SEG_BLANK;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (upd_req) begin
                                data_sh <= data_in;
                                dp_sh   <= dp_in;
                                en_sh   <= en_in;
                                upd_ack <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed table-driven bench for seg_scan_ctrl (4 digits, SCAN_DIV=4, BLANK_CYC=1)
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = '0;
    logic        upd_req = 1'b0;
    logic        upd_ack;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BLANK_CYC  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [31:0] seg;   // digit k expected seg at [8k +: 8]
        logic [15:0] an;    // digit k expected an at [4k +: 4]
    } vec_t;

    vec_t vecs [6];
    vec_t vzero;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (upd_ack) seen = 1'b1;
        end
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (frame_start) seen = 1'b1;
        end
        chk("frame_seen", seen, 1);
    endtask

    task automatic commit(input vec_t v);
        bit seen;
        data_in = v.data;
        dp_in   = v.dp;
        en_in   = v.en;
        upd_req = 1'b1;
        wait_ack(seen);
        chk("ack_seen", seen, 1);
        upd_req = 1'b0;
        step();
        chk("ack_width", upd_ack, 0);
        chk("frame_after_ack", frame_start, 1);
    endtask

    // Entered on the sample just after the digit-0 DRIVE edge; leaves in the BLANK after digit 3.
    task automatic check_frame(input vec_t v, input bit poke);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk($sformatf("an_d%0d", k), an, v.an[4*k +: 4]);
            chk($sformatf("seg_d%0d", k), seg, v.seg[8*k +: 8]);
            chk($sformatf("fs_d%0d", k), frame_start, (k == 0));
            if (poke && k == 1) begin
                data_in = ~v.data;
                dp_in   = ~v.dp;
                en_in   = ~v.en;
            end
            repeat (4) step();
            chk($sformatf("blank_an_d%0d", k), an, 4'hF);
            chk($sformatf("blank_seg_d%0d", k), seg, 8'hFF);
        end
    endtask

    initial begin
        int  acks;
        int  len;
        bit  seen;

        vecs[0] = '{16'h3210, 4'h2, 4'hF, 32'hB0A479C0, 16'h7BDE};
        vecs[1] = '{16'hFEDC, 4'h9, 4'hF, 32'h0E86A146, 16'h7BDE};
`ifdef SEG_SCAN_LZ_BLANK_EN
        vecs[2] = '{16'h0050, 4'h0, 4'hF, 32'hFFFF92C0, 16'h7BDE};
        vecs[3] = '{16'h0005, 4'h4, 4'hF, 32'hFF40C092, 16'h7BDE};
        vzero   = '{16'h0000, 4'h0, 4'hF, 32'hFFFFFFC0, 16'h7BDE};
`else
        vecs[2] = '{16'h0050, 4'h0, 4'hF, 32'hC0C092C0, 16'h7BDE};
        vecs[3] = '{16'h0005, 4'h4, 4'hF, 32'hC040C092, 16'h7BDE};
        vzero   = '{16'h0000, 4'h0, 4'hF, 32'hC0C0C0C0, 16'h7BDE};
`endif
        vecs[4] = '{16'h98BA, 4'h4, 4'h6, 32'hFF0083FF, 16'hFBDF};
        vecs[5] = '{16'h7654, 4'h0, 4'hB, 32'hF8FF9299, 16'h7FDE};

        // Reset state, then the first DRIVE one edge after release with a cleared (dark) shadow.
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_ack", upd_ack, 0);
        chk("rst_fs", frame_start, 0);
        rst_n = 1'b1;
        step();
        chk("first_fs", frame_start, 1);
        chk("first_an", an, 4'hF);
        chk("first_seg", seg, 8'hFF);

        for (int i = 0; i < 6; i++) begin
            commit(vecs[i]);
            check_frame(vecs[i], 1'b0);
        end

        // Tear-free: inputs change mid-frame with no request, nothing moves.
        step();
        chk("tf_fs", frame_start, 1);
        check_frame(vecs[5], 1'b1);
        chk("tf_no_ack", upd_ack, 0);
        step();
        check_frame(vecs[5], 1'b0);

        // Frame length with a disabled digit.
        wait_frame();
        len  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            len++;
            if (frame_start) seen = 1'b1;
        end
        chk("frame_len", len, 20);

        // Request held across two commit points yields two acks, then none.
        data_in = vecs[0].data;
        dp_in   = vecs[0].dp;
        en_in   = vecs[0].en;
        upd_req = 1'b1;
        wait_ack(seen);
        chk("dbl_ack_first", seen, 1);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (upd_ack) acks++;
        end
        chk("dbl_ack_second", acks, 1);
        upd_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (upd_ack) acks++;
        end
        chk("no_ack_idle", acks, 0);

        // Reset during digit-2 DRIVE.
        wait_frame();
        repeat (10) step();
        chk("pre_rst_an", an, 4'hB);
        chk("pre_rst_seg", seg, 8'hA4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_seg", seg, 8'hFF);
        upd_req = 1'b1;
        repeat (3) step();
        chk("rst_ack_low", upd_ack, 0);
        upd_req = 1'b0;
        rst_n   = 1'b1;
        step();
        chk("restart_fs", frame_start, 1);
        chk("restart_an", an, 4'hF);
        chk("restart_seg", seg, 8'hFF);
        commit(vzero);
        check_frame(vzero, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
